md_sequencer: RTL and testbench

//  Iterative RV32M multiply/divide sequencer beside the single-cycle ALU.

---
 rtl/md_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_md_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// md_sequencer
// Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU.
// Decode pulses start for M-extension ops. The block stalls the core until the
// result is ready. It retires one bit per cycle with a single shared adder:
// radix-2 shift-add for the multiplies and restoring division for DIV/REM.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous reset, active-high
//   start   launch an op; only looked at while idle
//   flush   abort whatever is in flight (branch/jal redirect); beats start
//   funct3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//           100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a    rs1 value (multiplicand / dividend)
//   op_b    rs2 value (multiplier / divisor)
//   busy    op in progress (CALC or FIX)
//   stall   core stall = busy | (start & idle), combinational
//   done    one-cycle pulse, result valid in this cycle
//   result  last completed result, held until the next op completes
module md_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);

   state_t state, next_state;

   logic [2:0]      op_q;
   logic            sign_a_q, sign_b_q, div_zero_q;
   logic [XLEN-1:0] mag_a_q, mag_b_q;
   logic [XLEN-1:0] hi_q, lo_q;
   logic [CNT_W-1:0] count_q;
   logic [XLEN-1:0] result_q;

   logic            a_signed, b_signed;
   logic            neg_a, neg_b;
   logic [XLEN-1:0] abs_a, abs_b;
   logic            is_div, div_zero, div_ovf, fast_path, accept;

   logic [XLEN:0]   add_x, add_y;
   logic            add_cin;
   logic [XLEN+1:0] sum;

   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, result_fix;

   // Work out which operands are treated as signed for the incoming op.
   // MUL shares the signed path with MULH because the low half of the
   // product is the same either way.
   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         3'b010: a_signed = 1'b1;
         default: begin
            a_signed = 1'b0;
            b_signed = 1'b0;
         end
      endcase
   end

   // Operand magnitudes and the two division corner cases that skip the
   // iterative loop entirely (divide by zero, and most-negative / -1).
   assign neg_a     = a_signed & op_a[XLEN-1];
   assign neg_b     = b_signed & op_b[XLEN-1];
   assign abs_a     = neg_a ? ({XLEN{1'b0}} - op_a) : op_a;
   assign abs_b     = neg_b ? ({XLEN{1'b0}} - op_b) : op_b;
   assign is_div    = funct3[2];
   assign div_zero  = is_div & (op_b == {XLEN{1'b0}});
   assign div_ovf   = is_div & ~funct3[0] & (op_a == MIN_NEG) & (op_b == {XLEN{1'b1}});
   assign fast_path = div_zero | div_ovf;
   assign accept    = (state == IDLE) & start & ~flush;

   // The one shared adder. For multiplies it adds the multiplicand into the
   // upper half when the current multiplier bit is set. For divides it does a
   // trial subtract of the divisor from the partial remainder shifted left by
   // one; the carry out of the top bit means the subtract did not go negative.
   always_comb begin
      if (op_q[2]) begin
         add_x   = {hi_q, lo_q[XLEN-1]};
         add_y   = ~{1'b0, mag_b_q};
         add_cin = 1'b1;
      end else begin
         add_x   = {1'b0, hi_q};
         add_y   = {1'b0, (lo_q[0] ? mag_a_q : {XLEN{1'b0}})};
         add_cin = 1'b0;
      end
      sum = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, add_cin};
   end

   // Sign correction and result selection, used in the FIX cycle. The
   // quotient of a divide by zero is all ones whatever the dividend sign, so
   // it is never negated. The remainder always follows the dividend's sign.
   always_comb begin
      prod       = {hi_q, lo_q};
      prod_fix   = (sign_a_q ^ sign_b_q) ? ({(2*XLEN){1'b0}} - prod) : prod;
      quot_fix   = ((sign_a_q ^ sign_b_q) & ~div_zero_q) ? ({XLEN{1'b0}} - lo_q) : lo_q;
      rem_fix    = sign_a_q ? ({XLEN{1'b0}} - hi_q) : hi_q;
      result_fix = {XLEN{1'b0}};
      case (op_q)
         3'b000:                 result_fix = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: result_fix = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         result_fix = quot_fix;
         default:                result_fix = rem_fix;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. A flush sends the block back to idle from anywhere.
   // Starts that arrive outside IDLE (including during DONE) are simply
   // ignored; the core re-issues once it sees the block idle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start) next_state = fast_path ? FIX : CALC;
         CALC: if (count_q == LAST_CNT) next_state = FIX;
         FIX:  next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (flush) next_state = IDLE;
   end

   // Datapath registers. On an accepted start the operands are captured so
   // the core is free to change op_a/op_b/funct3 afterwards. hi/lo hold the
   // product for multiplies and remainder/quotient for divides. The divide
   // fast paths preload hi/lo so that the ordinary FIX correction produces
   // the architecturally required answer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q       <= 3'b000;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         div_zero_q <= 1'b0;
         mag_a_q    <= {XLEN{1'b0}};
         mag_b_q    <= {XLEN{1'b0}};
         hi_q       <= {XLEN{1'b0}};
         lo_q       <= {XLEN{1'b0}};
         count_q    <= {CNT_W{1'b0}};
         result_q   <= {XLEN{1'b0}};
      end else begin
         if (accept) begin
            op_q       <= funct3;
            sign_a_q   <= neg_a;
            sign_b_q   <= neg_b;
            div_zero_q <= div_zero;
            mag_a_q    <= abs_a;
            mag_b_q    <= abs_b;
            count_q    <= {CNT_W{1'b0}};
            if (div_zero) begin
               hi_q <= abs_a;
               lo_q <= {XLEN{1'b1}};
            end else begin
               hi_q <= {XLEN{1'b0}};
               lo_q <= is_div ? abs_a : abs_b;
            end
         end else if (state == CALC) begin
            count_q <= count_q + CNT_W'(1);
            if (op_q[2]) begin
               if (sum[XLEN+1]) begin
                  hi_q <= sum[XLEN-1:0];
                  lo_q <= {lo_q[XLEN-2:0], 1'b1};
               end else begin
                  hi_q <= {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                  lo_q <= {lo_q[XLEN-2:0], 1'b0};
               end
            end else begin
               hi_q <= sum[XLEN:1];
               lo_q <= {sum[0], lo_q[XLEN-1:1]};
            end
         end
         if ((state == FIX) && !flush) begin
            result_q <= result_fix;
         end
      end
   end

   // Status outputs come straight from the state so they drop to zero the
   // moment reset is asserted.
   assign busy   = (state == CALC) | (state == FIX);
   assign done   = (state == DONE);
   assign stall  = busy | (start & (state == IDLE));
   assign result = result_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer
// Self-checking bench for md_sequencer. A latency/result model computes, from
// the RISC-V M-extension rules, what busy/stall/done/result must be on every
// cycle, and a compare process checks the DUT against it. Directed ops pin the
// documented values and latencies; a randomized phase then mixes starts,
// flushes and resets.
module tb_md_sequencer;

   localparam int XLEN = 32;

   logic        clk;
   logic        rst;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] result;

   int compared = 0;
   int failed   = 0;

   md_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .flush  (flush),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural result of an M-extension op, computed with 64-bit
   // arithmetic straight from the ISA definitions.
   function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      p  = 64'h0;
      case (f)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: begin
            if (b == 32'h0) return 32'hFFFFFFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            p = sa % sb;
            return p[31:0];
         end
         default: begin
            if (b == 32'h0) return a;
            return a % b;
         end
      endcase
   endfunction

   // Divide by zero and signed overflow finish two cycles after start.
   function automatic bit isFast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && ((b == 32'h0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: an accepted op is "age" edges old; it is busy until
   // its total latency is reached, shows done for exactly that one cycle and
   // then frees up. The result becomes visible in the done cycle.
   bit          m_active;
   int          m_age;
   int          m_total;
   logic [31:0] m_result;
   logic [31:0] m_pend;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_age    <= 0;
         m_total  <= 0;
         m_result <= 32'h0;
         m_pend   <= 32'h0;
      end else if (flush) begin
         m_active <= 1'b0;
      end else if (!m_active) begin
         if (start) begin
            m_active <= 1'b1;
            m_age    <= 1;
            m_total  <= isFast(funct3, op_a, op_b) ? 2 : XLEN + 2;
            m_pend   <= refResult(funct3, op_a, op_b);
         end
      end else begin
         m_age <= m_age + 1;
         if (m_age + 1 == m_total) m_result <= m_pend;
         if (m_age + 1 > m_total) m_active <= 1'b0;
      end
   end

   // Every cycle, well away from the rising edge, compare all outputs.
   always @(negedge clk) begin
      bit eb, ed, es;
      #2;
      eb = m_active && (m_age < m_total);
      ed = m_active && (m_age == m_total);
      es = eb || (start && !m_active);
      checkOutput("busy",   {31'b0, busy},  {31'b0, eb});
      checkOutput("done",   {31'b0, done},  {31'b0, ed});
      checkOutput("stall",  {31'b0, stall}, {31'b0, es});
      checkOutput("result", result, m_result);
   end

   // Issue one op and count edges until done is seen (bounded). With junk
   // set, start is held high with scrambled operands while the op runs,
   // including through the done cycle.
   task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                input bit junk, output int lat);
      @(negedge clk);
      start  = 1'b1;
      funct3 = f;
      op_a   = a;
      op_b   = b;
      @(negedge clk);
      start  = junk;
      funct3 = 3'($urandom);
      op_a   = $urandom;
      op_b   = $urandom;
      #2;
      lat = 1;
      while (!done && lat < 60) begin
         @(negedge clk);
         funct3 = 3'($urandom);
         op_a   = $urandom;
         op_b   = $urandom;
         #2;
         lat++;
      end
   endtask

   task automatic doOp(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input bit junk, input int exp_lat,
                       input logic [31:0] exp_res);
      int lat;
      applyStimulus(f, a, b, junk, lat);
      checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({name, "_result"}, result, exp_res);
      if (junk) begin
         @(negedge clk);
         start = 1'b0;
         #2;
         checkOutput({name, "_done_start_ignored"}, {31'b0, busy}, 32'h0);
      end
   endtask

   // Main sequence: reset, documented ops, flush/reset scenarios, then
   // randomized traffic checked by the model.
   initial begin
      int seen;
      rst    = 1'b0;
      start  = 1'b0;
      flush  = 1'b0;
      funct3 = 3'b000;
      op_a   = 32'h0;
      op_b   = 32'h0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      checkOutput("reset_busy",   {31'b0, busy},  32'h0);
      checkOutput("reset_done",   {31'b0, done},  32'h0);
      checkOutput("reset_stall",  {31'b0, stall}, 32'h0);
      checkOutput("reset_result", result,         32'h0);
      @(negedge clk);
      rst = 1'b0;

      doOp("mul",        3'd0, 32'd7,        32'hFFFFFFFD, 1'b0, 34, 32'hFFFFFFEB);
      doOp("mulh",       3'd1, 32'h80000000, 32'h80000000, 1'b0, 34, 32'h40000000);
      doOp("mulhu",      3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34, 32'hFFFFFFFE);
      doOp("mulhsu",     3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 34, 32'hFFFFFFFF);
      doOp("div",        3'd4, 32'hFFFFFFF9, 32'd2,        1'b0, 34, 32'hFFFFFFFD);
      doOp("rem",        3'd6, 32'hFFFFFFF9, 32'd2,        1'b0, 34, 32'hFFFFFFFF);
      doOp("divu",       3'd5, 32'd100,      32'd7,        1'b0, 34, 32'd14);
      doOp("remu",       3'd7, 32'd100,      32'd7,        1'b0, 34, 32'd2);
      doOp("div_zero",   3'd4, 32'd5,        32'd0,        1'b0, 2,  32'hFFFFFFFF);
      doOp("rem_zero",   3'd6, 32'd5,        32'd0,        1'b0, 2,  32'd5);
      doOp("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, 2,  32'h80000000);
      doOp("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, 2,  32'h0);
      doOp("div_busy",   3'd4, 32'hFFFFFFF9, 32'd2,        1'b1, 34, 32'hFFFFFFFD);

      // Flush in the middle of CALC: back to idle, no done, result kept.
      @(negedge clk);
      start  = 1'b1;
      funct3 = 3'd3;
      op_a   = 32'h12345678;
      op_b   = 32'h9ABCDEF0;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #2;
      checkOutput("flush_idle", {31'b0, busy}, 32'h0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         #2;
         if (done) seen++;
      end
      checkOutput("flush_no_done",     32'(seen), 32'h0);
      checkOutput("flush_result_kept", result,    32'hFFFFFFFD);
      doOp("after_flush", 3'd5, 32'd100, 32'd7, 1'b0, 34, 32'd14);

      // Flush and start together while idle: flush wins.
      @(negedge clk);
      start  = 1'b1;
      flush  = 1'b1;
      funct3 = 3'd0;
      op_a   = 32'd3;
      op_b   = 32'd4;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      #2;
      checkOutput("flush_beats_start", {31'b0, busy}, 32'h0);

      // Reset in the middle of CALC: outputs return to reset values at once.
      @(negedge clk);
      start  = 1'b1;
      funct3 = 3'd0;
      op_a   = 32'd9;
      op_b   = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #2;
      checkOutput("midop_reset_busy",   {31'b0, busy},  32'h0);
      checkOutput("midop_reset_done",   {31'b0, done},  32'h0);
      checkOutput("midop_reset_stall",  {31'b0, stall}, 32'h0);
      checkOutput("midop_reset_result", result,         32'h0);
      @(negedge clk);
      rst = 1'b0;
      doOp("after_reset", 3'd7, 32'd100, 32'd7, 1'b0, 34, 32'd2);

      // Randomized traffic; the model judges every cycle.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         start  = ($urandom_range(0, 3) == 0);
         flush  = ($urandom_range(0, 99) == 0);
         rst    = ($urandom_range(0, 499) == 0);
         funct3 = 3'($urandom);
         op_a   = pickOperand();
         op_b   = pickOperand();
      end
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      rst   = 1'b0;
      repeat (40) @(negedge clk);
      #3;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
